// File: rtl/periph_arbiter_pkg.sv
// Shared types for the peripheral bus arbiter.
// Store-type encoding is the core-wide one; the arbiter only forwards it.
package periph_arbiter_pkg;

  typedef enum logic [2:0] {
    MEM_STORE_NONE = 3'd0,
    MEM_STORE_B    = 3'd1,
    MEM_STORE_H    = 3'd2,
    MEM_STORE_W    = 3'd3,
    MEM_STORE_D    = 3'd4
  } mem_store_type_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    TIMEOUT = 2'd2
  } arb_state_t;

  localparam logic [63:0] ARB_TIMEOUT_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/periph_arb_rr_pick.sv
// Two-way round-robin select: on a tie the master that did not win
// last time is picked; a single requester always wins.
module periph_arb_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       any,
  output logic       pick
);

  assign any  = |valid;
  assign pick = (&valid) ? ~last_grant : valid[1];

endmodule

// File: rtl/periph_arbiter.sv
// Two-master arbiter for the shared peripheral bus.
// Optional BUSY watchdog enabled by PERIPH_ARB_TIMEOUT_EN.
module periph_arbiter
  import periph_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [63:0]     m0_addr,
  input  logic [63:0]     m0_wdata,
  input  mem_store_type_t m0_store_type,
  input  logic            m0_valid,
  output logic            m0_ready,
  output logic [63:0]     m0_rdata,
  input  logic [63:0]     m1_addr,
  input  logic [63:0]     m1_wdata,
  input  mem_store_type_t m1_store_type,
  input  logic            m1_valid,
  output logic            m1_ready,
  output logic [63:0]     m1_rdata,
  output logic [63:0]     bus_addr,
  output logic [63:0]     bus_wdata,
  output mem_store_type_t bus_store_type,
  output logic            bus_valid,
  input  logic            bus_ready,
  input  logic [63:0]     bus_rdata,
  output logic            grant,
  output logic            timeout_err
);

  arb_state_t  state, state_nxt;
  logic        grant_q, grant_nxt;
  logic        last_q, last_nxt;
  logic        any, pick;
  logic        g_valid;
  logic        done;
  logic [63:0] rd;

  periph_arb_rr_pick u_pick (
    .valid      ({m1_valid, m0_valid}),
    .last_grant (last_q),
    .any        (any),
    .pick       (pick)
  );

  assign g_valid = grant_q ? m1_valid : m0_valid;
  assign grant   = grant_q;

`ifdef PERIPH_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;

  // Counter restarts every arbitration cycle, i.e. on each BUSY entry
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE)
        cnt_q <= '0;
      else if (state == BUSY && !bus_ready)
        cnt_q <= cnt_q + 16'd1;
      if (state == TIMEOUT)
        err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    last_nxt       = last_q;
    bus_addr       = '0;
    bus_wdata      = '0;
    bus_store_type = MEM_STORE_NONE;
    bus_valid      = 1'b0;
    done           = 1'b0;
    rd             = '0;
    unique case (state)
      IDLE: begin
        if (any) begin
          grant_nxt = pick;
          if (m0_valid && m1_valid)
            last_nxt = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus_addr       = grant_q ? m1_addr : m0_addr;
        bus_wdata      = grant_q ? m1_wdata : m0_wdata;
        bus_store_type = grant_q ? m1_store_type : m0_store_type;
        bus_valid      = g_valid;
        // A completion on the last allowed cycle beats the watchdog
        if (!g_valid) begin
          state_nxt = IDLE;
        end else if (bus_ready) begin
          done      = 1'b1;
          rd        = bus_rdata;
          state_nxt = IDLE;
        end
`ifdef PERIPH_ARB_TIMEOUT_EN
        else if (cnt_q + 16'd1 == TIMEOUT_CYCLES) begin
          state_nxt = TIMEOUT;
        end
`endif
      end
`ifdef PERIPH_ARB_TIMEOUT_EN
      TIMEOUT: begin
        done      = 1'b1;
        rd        = ARB_TIMEOUT_RDATA;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_ready = done & ~grant_q;
  assign m1_ready = done & grant_q;
  assign m0_rdata = m0_ready ? rd : '0;
  assign m1_rdata = m1_ready ? rd : '0;

endmodule
